// File: rtl/ymp_apb_master.sv
// APB requester: turns one valid/ready request into a SETUP/ACCESS transfer and returns a held response.
// Define YMP_APB_MASTER_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES wait cycles.
module ymp_apb_master #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              rsp_timeout_o,
    output logic              busy_o,
    output logic [ADDR_W-1:0] paddr_o,
    output logic [DATA_W-1:0] pwdata_o,
    output logic              pwrite_o,
    output logic              psel_o,
    output logic              penable_o,
    input  logic [DATA_W-1:0] prdata_i,
    input  logic              pready_i,
    input  logic              pslverr_i
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t state;
    state_t state_next;

    logic handshake;
    logic access_done;
    logic expired;

    assign handshake   = req_valid_i && (state == IDLE);
    assign access_done = (state == ACCESS) && pready_i;

`ifdef YMP_APB_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_q;

    // Expiry is the last permitted wait cycle; a ready slave in that cycle still completes normally.
    assign expired = (state == ACCESS) && !pready_i &&
                     (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state == SETUP) begin
                wait_cnt <= '0;
            end else if ((state == ACCESS) && !pready_i) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (handshake) begin
                timeout_q <= 1'b0;
            end else if (expired) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign rsp_timeout_o = timeout_q;
`else
    assign expired       = 1'b0;
    assign rsp_timeout_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        req_ready_o = 1'b0;
        psel_o      = 1'b0;
        penable_o   = 1'b0;
        rsp_valid_o = 1'b0;
        busy_o      = 1'b1;
        case (state)
            IDLE: begin
                req_ready_o = 1'b1;
                busy_o      = 1'b0;
                if (req_valid_i) state_next = SETUP;
            end
            SETUP: begin
                psel_o     = 1'b1;
                state_next = ACCESS;
            end
            ACCESS: begin
                psel_o    = 1'b1;
                penable_o = 1'b1;
                if (access_done || expired) state_next = RESP;
            end
            RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Address/data latch at acceptance and stay put for the whole transfer; response fields only move on completion.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            paddr_o     <= '0;
            pwdata_o    <= '0;
            pwrite_o    <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            if (handshake) begin
                paddr_o     <= req_addr_i;
                pwdata_o    <= req_wdata_i;
                pwrite_o    <= req_write_i;
                rsp_rdata_o <= '0;
                rsp_err_o   <= 1'b0;
            end
            if (access_done) begin
                rsp_rdata_o <= pwrite_o ? '0 : prdata_i;
                rsp_err_o   <= pslverr_i;
            end else if (expired) begin
                rsp_rdata_o <= '0;
                rsp_err_o   <= 1'b1;
            end
        end
    end

endmodule

// File: doc/ymp_apb_master.md
YMP_APB_MASTER -- requirements
Module: ymp_apb_master

Interface
REQ-001 Parameter ADDR_W, default 32: width of the request address and of paddr_o.
REQ-002 Parameter DATA_W, default 32: width of the write data, read data, pwdata_o and prdata_i.
REQ-003 Parameter TIMEOUT_CYCLES, default 16: maximum number of ACCESS cycles waited for pready_i; only used when the timeout feature is compiled in.
REQ-004 The ports SHALL be, one per line: name  direction  width  meaning.
- clk_i  in  1  single clock; all logic on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- req_valid_i  in  1  transfer request valid.
- req_ready_o  out  1  request accepted on req_valid_i && req_ready_o.
- req_write_i  in  1  1 = write, 0 = read.
- req_addr_i  in  ADDR_W  transfer address.
- req_wdata_i  in  DATA_W  write data.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed on rsp_valid_o && rsp_ready_i.
- rsp_rdata_o  out  DATA_W  read data; 0 for writes.
- rsp_err_o  out  1  pslverr_i seen, or timeout.
- rsp_timeout_o  out  1  transfer aborted by timeout.
- busy_o  out  1  high in every state except IDLE.
- paddr_o  out  ADDR_W  APB address.
- pwdata_o  out  DATA_W  APB write data.
- pwrite_o  out  1  APB direction.
- psel_o  out  1  APB select.
- penable_o  out  1  APB enable.
- prdata_i  in  DATA_W  APB read data.
- pready_i  in  1  APB ready.
- pslverr_i  in  1  APB slave error.

Function
REQ-005 The block SHALL implement the FSM states IDLE, SETUP, ACCESS and RESP.
REQ-006 IDLE: req_ready_o=1; on handshake, latch addr/wdata/write into paddr_o/pwdata_o/pwrite_o and go to SETUP next cycle.
REQ-007 SETUP: psel_o=1, penable_o=0, lasting exactly one cycle, then ACCESS.
REQ-008 ACCESS: psel_o=1, penable_o=1; stay while pready_i=0; on pready_i=1, capture prdata_i (reads) or 0 (writes) into rsp_rdata_o and pslverr_i into rsp_err_o, then go to RESP.
REQ-009 RESP: psel_o=0, penable_o=0, rsp_valid_o=1, with the response fields held stable until rsp_ready_i=1, then IDLE.
REQ-010 req_ready_o SHALL be 0 outside IDLE; requests offered then are ignored, with no buffering.
REQ-011 paddr_o, pwdata_o and pwrite_o SHALL be stable from SETUP through the final ACCESS cycle.
REQ-012 Latency with zero-wait slave: handshake edge N; SETUP cycle N+1; ACCESS N+2; rsp_valid_o high from N+3; minimum 4 cycles per transfer with rsp_ready_i held 1.
REQ-013 pslverr_i SHALL be sampled only in the ACCESS cycle where pready_i=1.

Reset
REQ-014 When rst_i=1 at a clock edge: FSM to IDLE; psel_o, penable_o, rsp_valid_o, rsp_err_o, rsp_timeout_o, busy_o = 0; paddr_o, pwdata_o, rsp_rdata_o = 0; pwrite_o=0; req_ready_o=1 from the first cycle after reset.
REQ-015 Reset mid-transfer (SETUP/ACCESS/RESP) SHALL abort it with no response produced; psel_o and penable_o are low the cycle after the reset edge.

Configuration
REQ-016 Macro YMP_APB_MASTER_TIMEOUT_EN defined: a counter clears on entering ACCESS and increments each ACCESS cycle with pready_i=0.
- After TIMEOUT_CYCLES such cycles, the block drops psel_o/penable_o and enters RESP with rsp_err_o=1, rsp_timeout_o=1, rsp_rdata_o=0.
- pready_i=1 in the same cycle as expiry SHALL win and complete normally.
REQ-017 Macro undefined: no counter is built, ACCESS waits indefinitely, and rsp_timeout_o is tied 0.

Verification
REQ-018 Write addr 0x10, wdata 0xDEADBEEF, pready_i=1 always -> SETUP then ACCESS, one cycle each, with matching paddr_o/pwdata_o/pwrite_o=1; rsp_valid_o at handshake+3; rsp_err_o=0; rsp_rdata_o=0.
REQ-019 Read addr 0x04, slave adds 3 wait states, prdata_i=0x12345678 -> ACCESS lasts 4 cycles; rsp_rdata_o=0x12345678.
REQ-020 Read with pslverr_i=1 on the ready cycle, rsp_ready_i held 0 for 5 cycles -> rsp_valid_o and rsp_err_o=1 held 5 cycles; req_ready_o=0 throughout.
REQ-021 Macro defined, TIMEOUT_CYCLES=16, pready_i=0 forever -> abort after 16 ACCESS cycles with rsp_err_o=1 and rsp_timeout_o=1; repeat with pready_i=1 on cycle 16 -> normal completion, rsp_timeout_o=0.
REQ-022 rst_i=1 during ACCESS of a read -> next cycle psel_o=0, penable_o=0, rsp_valid_o=0, req_ready_o=1; the next request completes normally.
